// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state/owner encodings for the IF/LS memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Wide enough for any TIMEOUT in 1..255.
  localparam int         CNT_W = 8;
  localparam logic [3:0] IF_BE = 4'hF;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_IF) ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rtl/mem_port_arbiter_rr_arb2.sv - 2-way round-robin pick; a tie goes to the port that did not own last
module mem_port_arbiter_rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_last_owner,
  output logic       o_valid,
  output owner_t     o_pick
);

  always_comb begin
    o_pick = OWN_IF;
    case (i_req)
      2'b01:   o_pick = OWN_IF;
      2'b10:   o_pick = OWN_LS;
      2'b11:   o_pick = other_owner(i_last_owner);
      default: o_pick = OWN_IF;
    endcase
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/mux21.sv
// rtl/mux21.sv - generic 2:1 select, i_sel=1 picks i_d1
module mux21 #(
  parameter int W = 1
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, one transaction at a time
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_err,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [3:0]    i_ls_be,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [DW-1:0] o_ls_rdata,
  output logic          o_ls_err,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [3:0]    o_mem_be,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ready,
  input  logic          i_mem_rvalid,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int RW = 1 + 4 + AW + DW;

  state_t           r_state;
  state_t           w_next;
  owner_t           r_owner;
  owner_t           r_last_owner;
  owner_t           w_pick;
  logic             w_arb_valid;
  logic             w_grant;
  logic             w_timeout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_we;
  logic [3:0]       r_be;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_if_rdata;
  logic [DW-1:0]    r_ls_rdata;
  logic [RW-1:0]    w_if_fields;
  logic [RW-1:0]    w_ls_fields;
  logic [RW-1:0]    w_sel_fields;

  mem_port_arbiter_rr_arb2 u_arb (
    .i_req        ({i_ls_req, i_if_req}),
    .i_last_owner (r_last_owner),
    .o_valid      (w_arb_valid),
    .o_pick       (w_pick)
  );

  // Fetches are always full-word reads; the write-data lane is unused for them.
  assign w_if_fields = {1'b0, IF_BE, i_if_addr, {DW{1'b0}}};
  assign w_ls_fields = {i_ls_we, i_ls_be, i_ls_addr, i_ls_wdata};

  mux21 #(.W(RW)) u_req_mux (
    .i_sel (w_pick == OWN_LS),
    .i_d0  (w_if_fields),
    .i_d1  (w_ls_fields),
    .o_y   (w_sel_fields)
  );

  assign w_grant   = (r_state == ST_IDLE) && w_arb_valid;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_arb_valid) w_next = ST_ISSUE;
      ST_ISSUE:    if (i_mem_ready) w_next = ST_WAIT_RSP;
      ST_WAIT_RSP: if (i_mem_rvalid || w_timeout) w_next = ST_RESP;
      ST_RESP:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner      <= OWN_IF;
      r_last_owner <= OWN_IF;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_owner                        <= w_pick;
        {r_we, r_be, r_addr, r_wdata}  <= w_sel_fields;
        r_err                          <= 1'b0;
      end
      if (r_state == ST_ISSUE && i_mem_ready) r_cnt <= '0;
      if (r_state == ST_WAIT_RSP) begin
        // A response arriving on the last allowed cycle still counts as a response.
        if (i_mem_rvalid) begin
          if (r_owner == OWN_IF) r_if_rdata <= i_mem_rdata;
          else                   r_ls_rdata <= i_mem_rdata;
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (r_state == ST_RESP) r_last_owner <= r_owner;
    end
  end

  assign o_if_gnt    = w_grant && (w_pick == OWN_IF);
  assign o_ls_gnt    = w_grant && (w_pick == OWN_LS);
  assign o_if_rvalid = (r_state == ST_RESP) && (r_owner == OWN_IF) && !r_err;
  assign o_ls_rvalid = (r_state == ST_RESP) && (r_owner == OWN_LS) && !r_err;
  assign o_if_err    = (r_state == ST_RESP) && (r_owner == OWN_IF) && r_err;
  assign o_ls_err    = (r_state == ST_RESP) && (r_owner == OWN_LS) && r_err;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_mem_req   = (r_state == ST_ISSUE);
  assign o_mem_we    = r_we;
  assign o_mem_be    = r_be;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule
